// File: rtl/reg_read_stage.sv
// Register-read stage: resolves source operands against a per-register pending-write
// scoreboard, bypasses same-cycle commits, and holds one instruction in an output register.
module reg_read_stage #(
    parameter int XLEN  = 32,
    parameter int IID_W = 8,
    parameter int SB_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [31:0]           in_inst,
    input  logic [IID_W-1:0]      in_inst_id,
    input  logic [4:0]            in_rs1_addr,
    input  logic [4:0]            in_rs2_addr,
    input  logic                  in_rs1_use,
    input  logic                  in_rs2_use,
    input  logic                  in_rf_wen,
    input  logic [4:0]            in_rd_addr,
    input  logic [31:0][XLEN-1:0] regfile,
    input  logic                  wb_valid,
    input  logic                  wb_rf_wen,
    input  logic [4:0]            wb_reg_addr,
    input  logic [XLEN-1:0]       wb_wdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [31:0]           out_inst,
    output logic [IID_W-1:0]      out_inst_id,
    output logic                  out_rf_wen,
    output logic [4:0]            out_rd_addr,
    output logic [XLEN-1:0]       out_rs1_data,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [31:0]           stall_cycles,
    output logic                  sb_underflow
);

    localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);
    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [31:0][SB_W-1:0] cnt_view;
    logic [31:0]           uf_hit;
    logic                  wb_commit;
    logic                  waw_block;
    logic                  fire;
    logic [1:0][4:0]       src_addr;
    logic [1:0]            src_use;
    logic [1:0]            src_block;
    logic [1:0][XLEN-1:0]  src_data;

    assign wb_commit = wb_valid & wb_rf_wen;
    assign src_addr  = {in_rs2_addr, in_rs1_addr};
    assign src_use   = {in_rs2_use, in_rs1_use};

    // Index 0 is rs1, index 1 is rs2. A single pending writer may be satisfied
    // by a commit of the same register in this very cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [SB_W-1:0] cnt_s;
            logic            live;
            logic            hit;

            assign cnt_s = cnt_view[src_addr[gi]];
            assign live  = src_use[gi] & (src_addr[gi] != 5'd0);
            assign hit   = wb_commit & (wb_reg_addr == src_addr[gi]);
            assign src_block[gi] = live & ((cnt_s > CNT_ONE) | ((cnt_s == CNT_ONE) & !hit));
            assign src_data[gi]  = !live ? '0 :
                                   ((cnt_s == CNT_ONE) & hit) ? wb_wdata :
                                   regfile[src_addr[gi]];
        end
    endgenerate

    assign waw_block = in_rf_wen & (in_rd_addr != 5'd0) & (cnt_view[in_rd_addr] == CNT_MAX);
    assign in_ready  = !flush & !(|src_block) & !waw_block & (!out_valid | out_ready);
    assign fire      = in_valid & in_ready;

    // x0 never has writers in flight; every other register owns a pending counter.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_view[gi] = '0;
                assign uf_hit[gi]   = 1'b0;
            end else begin : g_reg
                logic [SB_W-1:0] cnt_reg;
                logic            inc;
                logic            dec;

                assign inc = fire & in_rf_wen & (in_rd_addr == 5'(gi));
                assign dec = wb_commit & (wb_reg_addr == 5'(gi));
                assign uf_hit[gi]   = dec & !inc & (cnt_reg == '0);
                assign cnt_view[gi] = cnt_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else if (flush) begin
                        cnt_reg <= '0;
                    end else if (inc & !dec) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else if (dec & !inc & (cnt_reg != '0)) begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_inst     <= '0;
            out_inst_id  <= '0;
            out_rf_wen   <= 1'b0;
            out_rd_addr  <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_inst     <= in_inst;
            out_inst_id  <= in_inst_id;
            out_rf_wen   <= in_rf_wen;
            out_rd_addr  <= in_rd_addr;
            out_rs1_data <= src_data[0];
            out_rs2_data <= src_data[1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            sb_underflow <= 1'b0;
        end else begin
            if (in_valid & !in_ready & !flush & (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (!flush & (|uf_hit)) begin
                sb_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed hazard scenarios plus random traffic, checked by a
// pending-writer reference model and an output scoreboard drained by a separate monitor.
module tb_reg_read_stage;

    localparam int XLEN  = 32;
    localparam int IID_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  in_valid, in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [31:0]           in_inst;
    logic [IID_W-1:0]      in_inst_id;
    logic [4:0]            in_rs1_addr, in_rs2_addr;
    logic                  in_rs1_use, in_rs2_use;
    logic                  in_rf_wen;
    logic [4:0]            in_rd_addr;
    logic [31:0][XLEN-1:0] regfile;
    logic                  wb_valid, wb_rf_wen;
    logic [4:0]            wb_reg_addr;
    logic [XLEN-1:0]       wb_wdata;
    logic                  flush;
    logic                  out_valid, out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [31:0]           out_inst;
    logic [IID_W-1:0]      out_inst_id;
    logic                  out_rf_wen;
    logic [4:0]            out_rd_addr;
    logic [XLEN-1:0]       out_rs1_data, out_rs2_data;
    logic [31:0]           stall_cycles;
    logic                  sb_underflow;

    reg_read_stage #(.XLEN(XLEN), .IID_W(IID_W), .SB_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_inst_id(in_inst_id),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
        .in_rf_wen(in_rf_wen), .in_rd_addr(in_rd_addr),
        .regfile(regfile),
        .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen),
        .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_inst_id(out_inst_id),
        .out_rf_wen(out_rf_wen), .out_rd_addr(out_rd_addr),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .stall_cycles(stall_cycles), .sb_underflow(sb_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic [31:0]      inst;
        logic [IID_W-1:0] id;
        logic             wen;
        logic [4:0]       rd;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     tests = 0;
    int     fails = 0;
    int     pend[32];
    bit     out_full;
    longint stall_exp;
    bit     uf_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got pc 0x%0h expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] out id=%0h pc=%h rd=%0d wen=%0b rs1=%h rs2=%h",
                         out_inst_id, out_pc, out_rd_addr, out_rf_wen, out_rs1_data, out_rs2_data);
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_inst", out_inst, mon_e.inst);
                chk("out_inst_id", out_inst_id, mon_e.id);
                chk("out_rf_wen", out_rf_wen, mon_e.wen);
                chk("out_rd_addr", out_rd_addr, mon_e.rd);
                chk("out_rs1_data", out_rs1_data, mon_e.a);
                chk("out_rs2_data", out_rs2_data, mon_e.b);
            end
        end
    end

    function automatic bit commits(input logic [4:0] a);
        return wb_valid && wb_rf_wen && (wb_reg_addr == a);
    endfunction

    function automatic bit src_blocked(input bit use_s, input logic [4:0] a);
        if (!use_s || a == 0) return 1'b0;
        if (pend[a] >= 2) return 1'b1;
        return (pend[a] == 1) && !commits(a);
    endfunction

    function automatic logic [XLEN-1:0] operand(input bit use_s, input logic [4:0] a);
        if (!use_s || a == 0) return '0;
        if (pend[a] == 1 && commits(a)) return wb_wdata;
        return regfile[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        out_full  = 1'b0;
        stall_exp = 0;
        uf_exp    = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_inst_id = '0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_use = 1'b0; in_rs2_use = 1'b0;
        in_rf_wen = 1'b0; in_rd_addr = '0;
        wb_valid = 1'b0; wb_rf_wen = 1'b0; wb_reg_addr = '0; wb_wdata = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic set_inst(input bit v, input logic [4:0] r1, input bit u1,
                            input logic [4:0] r2, input bit u2, input bit wen, input logic [4:0] rd);
        in_valid = v; in_pc = $urandom; in_inst = $urandom; in_inst_id = IID_W'($urandom);
        in_rs1_addr = r1; in_rs1_use = u1; in_rs2_addr = r2; in_rs2_use = u2;
        in_rf_wen = wen; in_rd_addr = rd;
    endtask

    task automatic set_wb(input bit v, input bit wen, input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_valid = v; wb_rf_wen = wen; wb_reg_addr = a; wb_wdata = d;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic run_cycle(output bit rdy);
        bit   exp_ready, fire, commit, same;
        exp_t e;
        #2;
        exp_ready = !flush
                    && !src_blocked(in_rs1_use, in_rs1_addr)
                    && !src_blocked(in_rs2_use, in_rs2_addr)
                    && !(in_rf_wen && in_rd_addr != 0 && pend[in_rd_addr] == 3)
                    && (!out_full || out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, out_full);
        chk("stall_cycles", stall_cycles, stall_exp);
        chk("sb_underflow", sb_underflow, uf_exp);
        rdy  = in_ready;
        fire = in_valid && exp_ready;
        if (flush && out_full && !out_ready && exp_q.size() > 0) exp_q.delete(0);
        if (fire) begin
            e.pc = in_pc; e.inst = in_inst; e.id = in_inst_id; e.wen = in_rf_wen; e.rd = in_rd_addr;
            e.a = operand(in_rs1_use, in_rs1_addr);
            e.b = operand(in_rs2_use, in_rs2_addr);
            exp_q.push_back(e);
        end
        if (in_valid && !exp_ready && !flush && stall_exp < 64'hFFFF_FFFF) stall_exp++;
        commit = wb_valid && wb_rf_wen && wb_reg_addr != 0 && !flush;
        same   = commit && fire && in_rf_wen && in_rd_addr == wb_reg_addr;
        if (flush) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else if (!same) begin
            if (fire && in_rf_wen && in_rd_addr != 0) pend[in_rd_addr]++;
            if (commit) begin
                if (pend[wb_reg_addr] == 0) uf_exp = 1'b1;
                else pend[wb_reg_addr]--;
            end
        end
        if (flush) out_full = 1'b0;
        else if (fire) out_full = 1'b1;
        else if (out_ready) out_full = 1'b0;
        @(posedge clk);
        if (commit) regfile[wb_reg_addr] = wb_wdata;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r;
        int rr;
        idle();
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        regfile[0] = 32'hDEAD_BEEF;
        regfile[1] = 32'd7;
        regfile[2] = 32'd9;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rs1", out_rs1_data, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_underflow", sb_underflow, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Independent back-to-back issue, first fire right after reset release.
        set_inst(1, 0, 1, 0, 0, 1, 5);
        run_cycle(r); chk("indep_addi_ready", r, 1);
        set_inst(1, 1, 1, 2, 1, 1, 6);
        run_cycle(r); chk("indep_add_ready", r, 1);
        chk("indep_rs1", out_rs1_data, 32'd7);
        chk("indep_rs2", out_rs2_data, 32'd9);

        // RAW stall on x5, released by a same-cycle commit with bypass.
        set_inst(1, 5, 1, 0, 0, 0, 0);
        repeat (3) begin run_cycle(r); chk("raw_stall_ready", r, 0); end
        chk("raw_stall_count", stall_cycles, 3);
        set_wb(1, 1, 5, 32'h1234);
        run_cycle(r); chk("raw_commit_ready", r, 1);
        chk("raw_bypass_data", out_rs1_data, 32'h1234);
        set_wb(0, 0, 0, 0);
        set_inst(1, 5, 1, 5, 1, 0, 0);
        run_cycle(r); chk("raw_cnt_cleared", r, 1);

        // Same-cycle issue and commit of x5; x0 always reads zero.
        set_inst(1, 0, 0, 0, 0, 1, 5);
        run_cycle(r); chk("same_first_writer", r, 1);
        set_inst(1, 0, 1, 0, 1, 1, 5);
        set_wb(1, 1, 5, 32'hCAFE);
        run_cycle(r); chk("same_cycle_ready", r, 1);
        chk("x0_rs1_zero", out_rs1_data, 0);
        chk("x0_rs2_zero", out_rs2_data, 0);
        set_wb(0, 0, 0, 0);
        set_inst(1, 5, 1, 0, 0, 0, 0);
        run_cycle(r); chk("same_cycle_cnt_held", r, 0);
        set_inst(1, 0, 1, 0, 1, 0, 0);
        set_wb(1, 1, 0, 32'h5555_AAAA);
        run_cycle(r); chk("x0_bypass_ready", r, 1);
        chk("x0_bypass_zero", out_rs1_data, 0);
        set_inst(1, 5, 1, 0, 0, 0, 0);
        set_wb(1, 1, 5, 32'h77);
        run_cycle(r); chk("x5_release_ready", r, 1);

        // Backpressure hold, then flush.
        idle();
        run_cycle(r);
        out_ready = 1'b0;
        set_inst(1, 1, 1, 2, 1, 1, 9);
        run_cycle(r); chk("bp_fire_ready", r, 1);
        set_inst(1, 3, 1, 4, 1, 0, 0);
        repeat (3) begin
            run_cycle(r); chk("bp_ready_low", r, 0);
            if (exp_q.size() > 0) begin
                chk("bp_pc_stable", out_pc, exp_q[0].pc);
                chk("bp_rs1_stable", out_rs1_data, exp_q[0].a);
            end else begin
                tests++; fails++;
                $display("FAIL bp_held_item: got empty queue expected held item");
            end
        end
        flush = 1'b1;
        run_cycle(r);
        chk("flush_out_valid", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b1;
        set_inst(1, 9, 1, 6, 1, 0, 0);
        run_cycle(r); chk("flush_cnt_cleared", r, 1);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            set_inst(($urandom % 10) < 7, 5'($urandom % 8), 1'($urandom), 5'($urandom % 8),
                     1'($urandom), 1'($urandom), 5'($urandom % 8));
            out_ready = ($urandom % 10) < 7;
            flush = ($urandom % 40) == 0;
            rr = $urandom_range(1, 7);
            if (pend[rr] > 0 && ($urandom % 2) == 1) set_wb(1, 1, 5'(rr), $urandom);
            else if (($urandom % 8) == 0) set_wb(1, 0, 5'($urandom), $urandom);
            else set_wb(0, 1'($urandom), 5'($urandom), $urandom);
            run_cycle(r);
        end

        idle();
        flush = 1'b1;
        run_cycle(r);
        flush = 1'b0;

        // WAW limit: the fourth outstanding writer of x7 must stall.
        for (int i = 0; i < 4; i++) begin
            set_inst(1, 0, 0, 0, 0, 1, 7);
            run_cycle(r); chk("waw_ready", r, (i < 3) ? 1 : 0);
        end
        idle();
        flush = 1'b1;
        run_cycle(r);
        flush = 1'b0;

        // Commit with no pending writer sets the sticky error.
        set_wb(1, 1, 3, 32'h3333);
        run_cycle(r);
        chk("underflow_set", sb_underflow, 1);
        set_wb(0, 0, 0, 0);
        flush = 1'b1;
        run_cycle(r);
        flush = 1'b0;
        repeat (2) run_cycle(r);
        chk("underflow_sticky", sb_underflow, 1);

        // Reset in the middle of a held instruction.
        out_ready = 1'b0;
        set_inst(1, 0, 0, 0, 0, 1, 7);
        run_cycle(r); chk("pre_reset_fire", r, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_pc", out_pc, 0);
        chk("rst_mid_underflow", sb_underflow, 0);
        chk("rst_mid_stall", stall_cycles, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        set_inst(1, 7, 1, 0, 0, 1, 8);
        run_cycle(r); chk("rst_cnt_cleared", r, 1);
        idle();
        repeat (3) run_cycle(r);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data/address width; IID_W, default 8, instruction-id width; SB_W, default 2, per-register pending-write counter width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  PC
- in_inst  in  32  instruction word
- in_inst_id  in  IID_W  instruction id
- in_rs1_addr, in_rs2_addr  in  5 each  source register indices
- in_rs1_use, in_rs2_use  in  1 each  source is actually read
- in_rf_wen  in  1  instruction writes rd
- in_rd_addr  in  5  destination index
- regfile  in  32 x XLEN  architectural register array from the writeback stage
- wb_valid, wb_rf_wen  in  1 each  writeback commit this cycle
- wb_reg_addr  in  5  committed register index
- wb_wdata  in  XLEN  committed value
- flush  in  1  squash the stage
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream accepts
- out_pc, out_inst, out_inst_id, out_rf_wen, out_rd_addr  out  registered copies of the inputs
- out_rs1_data, out_rs2_data  out  XLEN each  resolved operands
- stall_cycles  out  32  hazard stall counter
- sb_underflow  out  1  sticky scoreboard error

Function
REQ-003 SHALL keep 32 pending counters cnt[r] of SB_W bits; cnt[0] SHALL always read 0.
REQ-004 A source s (rs1 or rs2) SHALL be blocked when: s_use=1, addr!=0, cnt[addr]>=2, or cnt[addr]==1 with no matching commit this cycle.
- Matching commit: wb_valid & wb_rf_wen & wb_reg_addr==addr.
REQ-005 in_rf_wen=1 with rd!=0 and cnt[rd] at maximum (3) SHALL block (WAW overflow).
REQ-006 Operand selection:
- addr==0 or use=0: 0
- cnt[addr]==1 with a matching commit: wb_wdata (same-cycle bypass)
- otherwise: regfile[addr]
REQ-007 in_ready SHALL be combinational = !flush & !blocked & (!out_valid | out_ready); it SHALL NOT depend on in_valid.
REQ-008 fire = in_valid & in_ready; on fire the output register SHALL load all out_* fields and set out_valid=1 at the next edge (latency 1 cycle).
REQ-009 With no fire and out_ready=1, out_valid SHALL clear; with out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-010 cnt[rd] SHALL increment on fire with in_rf_wen=1 and rd!=0.
REQ-011 cnt[wb_reg_addr] SHALL decrement on wb_valid & wb_rf_wen & wb_reg_addr!=0.
REQ-012 If increment and decrement target the same register in the same cycle, that counter SHALL be unchanged.
REQ-013 A decrement at cnt==0 SHALL leave cnt at 0 and set sb_underflow, which holds until reset.
REQ-014 flush=1 SHALL force in_ready=0, clear out_valid, and zero all counters at the next edge; a commit in the same cycle SHALL be ignored.
- The pipeline SHALL assert flush only when every uncommitted downstream writer is also squashed.
REQ-015 stall_cycles SHALL increment in each cycle with in_valid=1, in_ready=0 and flush=0, saturating at 0xFFFFFFFF.
REQ-016 Ids SHALL pass through unchanged; no arithmetic on pc or inst.

Reset
REQ-017 While rst_n=0, asynchronously:
- out_valid=0
- all out_* data fields = 0
- all cnt = 0
- stall_cycles = 0
- sb_underflow = 0
REQ-018 Reset asserted mid-operation SHALL discard the held instruction and all pending state.
REQ-019 The first fire SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-020 Independent flow: issue "addi x5" (rf_wen, rd=5), then "add x6,x1,x2" back-to-back, out_ready=1, regfile[1]=7, regfile[2]=9 -> both fire in consecutive cycles; out_rs1_data=7, out_rs2_data=9; cnt[5]=1, cnt[6]=1.
REQ-021 RAW stall: cnt[5]=1, instruction reads x5, no commit -> in_ready=0 and stall_cycles increments each cycle; then commit x5 with wb_wdata=0x1234 -> fires that cycle with out_rs1_data=0x1234 and cnt[5] back to 0 after the edge.
REQ-022 Same-cycle issue and commit: fire writing x5 while committing x5, cnt[5]=1 -> cnt[5] stays 1; reading x0 returns 0 even when regfile or the bypass carries nonzero data.
REQ-023 Backpressure and flush: out_valid=1, out_ready=0 for 3 cycles -> out_* stable and in_ready=0; then flush=1 -> out_valid=0 and all cnt=0 next cycle.
REQ-024 Limits: four writers to x7 without commits -> the fourth stalls (cnt[7]=3); commit x3 with cnt[3]=0 -> sb_underflow=1 and it stays 1; rst_n=0 mid-stream -> out_valid=0 immediately.
